// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer: PS/2 scan-code prefix decoder feeding an event FIFO, press counter and held-key tracker.
// Optional KBD_TYPEMATIC_FILTER_EN drops typematic repeats of the held key.
module ps2_key_sequencer #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic [7:0] press_count,
  output logic       held,
  output logic [8:0] held_code,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  state_t state_q, state_d;
  logic [AW:0] wr_q, rd_q;
  logic [9:0] mem_q [FIFO_DEPTH];
  logic [7:0] count_q;
  logic held_q, ovf_q;
  logic [8:0] held_code_q;
  logic is_e0, is_f0, is_err, go, ext, brk, rep, push, pop, full, empty;
  logic [9:0] head;
  always_comb begin
    is_e0 = byte_data == 8'hE0;
    is_f0 = byte_data == 8'hF0;
    is_err = byte_data == 8'h00 || byte_data == 8'hFF;
    ext = state_q == EXT || state_q == EXT_BRK;
    brk = state_q == BRK || state_q == EXT_BRK;
    go = byte_valid & ~is_e0 & ~is_f0 & ~is_err;
`ifdef KBD_TYPEMATIC_FILTER_EN
    rep = go & ~brk & held_q & ({ext, byte_data} == held_code_q);
`else
    rep = 1'b0;
`endif
    push = go & ~rep;
    empty = wr_q == rd_q;
    full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop = ~empty & evt_ready;
    state_d = !byte_valid ? state_q :
              state_q == IDLE ? (is_e0 ? EXT : is_f0 ? BRK : IDLE) :
              state_q == EXT ? (is_f0 ? EXT_BRK : is_e0 ? EXT : IDLE) : IDLE;
    head = empty ? 10'd0 : mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      held_q <= 1'b0;
      held_code_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) rd_q <= rd_q + 1'b1;
      if (push && (!full || pop)) wr_q <= wr_q + 1'b1;
      if (push && full && !pop) ovf_q <= 1'b1;
      if (go && !brk && !rep) begin
        count_q <= count_q + 8'd1;
        held_q <= 1'b1;
        held_code_q <= {ext, byte_data};
      end
      if (go && brk && {ext, byte_data} == held_code_q) held_q <= 1'b0;
    end
  end
  // Storage is never reset; the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (!rst && push && (!full || pop)) mem_q[wr_q[AW-1:0]] <= {byte_data, ext, brk};
  end
  assign evt_valid = ~empty;
  assign {evt_code, evt_ext, evt_break} = head;
  assign press_count = count_q;
  assign held = held_q;
  assign held_code = held_code_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_ps2_key_sequencer.sv
// tb_ps2_key_sequencer: table vectors, directed corner sequences and a randomized queue-based reference model.
module tb_ps2_key_sequencer;
  localparam int DEPTH = 8;
`ifdef KBD_TYPEMATIC_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, byte_valid = 1'b0, evt_ready = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic evt_valid, evt_ext, evt_break, held, overflow;
  logic [7:0] evt_code, press_count;
  logic [8:0] held_code;
  int checks = 0, failures = 0;
  logic [9:0] got[$];
  logic [9:0] mq[$];
  bit mext, mbrk, mheld, movf;
  logic [7:0] mpc;
  logic [8:0] mhc;

  ps2_key_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_break(evt_break), .press_count(press_count),
    .held(held), .held_code(held_code), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic bv, input logic [7:0] b, input logic rdy, input logic r);
    byte_valid = bv;
    byte_data = b;
    evt_ready = rdy;
    rst = r;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    evt_ready = 1'b0;
    rst = 1'b0;
  endtask

  task automatic drain();
    got.delete();
    for (int k = 0; k < 2 * DEPTH + 4 && evt_valid; k++) begin
      got.push_back({evt_code, evt_ext, evt_break});
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

  task automatic model_evt(input bit e, input bit k, input logic [7:0] b);
    bit rep;
    rep = FILT && !k && mheld && ({e, b} == mhc);
    if (k && {e, b} == mhc) mheld = 1'b0;
    if (!k && !rep) begin
      mpc = mpc + 8'd1;
      mheld = 1'b1;
      mhc = {e, b};
    end
    if (!rep) begin
      if (mq.size() < DEPTH) mq.push_back({b, e, k});
      else movf = 1'b1;
    end
  endtask

  task automatic model_step(input logic bv, input logic [7:0] b, input logic rdy, input logic r);
    if (r) begin
      mq.delete();
      {mext, mbrk, mheld, movf} = '0;
      mpc = '0;
      mhc = '0;
    end else begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (bv) begin
        if (b == 8'h00 || b == 8'hFF) {mext, mbrk} = 2'b00;
        else if (b == 8'hE0 || b == 8'hF0) begin
          if (mbrk) {mext, mbrk} = 2'b00;
          else if (b == 8'hE0) mext = 1'b1;
          else mbrk = 1'b1;
        end else begin
          model_evt(mext, mbrk, b);
          {mext, mbrk} = 2'b00;
        end
      end
    end
  endtask

  typedef struct {
    logic [7:0] b;
    logic ev;
    logic [7:0] code;
    logic ext;
    logic brk;
    logic [7:0] pc;
    logic hld;
    logic [8:0] hc;
  } vec_t;
  vec_t tbl[24];
  logic [7:0] ov[9];
  logic [7:0] pool[12];

  initial begin
    tbl[0]  = '{8'h1C, 1, 8'h1C, 0, 0, 8'd1, 1, 9'h01C};
    tbl[1]  = '{8'hF0, 0, 8'h00, 0, 0, 8'd1, 1, 9'h01C};
    tbl[2]  = '{8'h1C, 1, 8'h1C, 0, 1, 8'd1, 0, 9'h01C};
    tbl[3]  = '{8'hE0, 0, 8'h00, 0, 0, 8'd1, 0, 9'h01C};
    tbl[4]  = '{8'h75, 1, 8'h75, 1, 0, 8'd2, 1, 9'h175};
    tbl[5]  = '{8'hE0, 0, 8'h00, 0, 0, 8'd2, 1, 9'h175};
    tbl[6]  = '{8'hF0, 0, 8'h00, 0, 0, 8'd2, 1, 9'h175};
    tbl[7]  = '{8'h75, 1, 8'h75, 1, 1, 8'd2, 0, 9'h175};
    tbl[8]  = '{8'h00, 0, 8'h00, 0, 0, 8'd2, 0, 9'h175};
    tbl[9]  = '{8'hE0, 0, 8'h00, 0, 0, 8'd2, 0, 9'h175};
    tbl[10] = '{8'hFF, 0, 8'h00, 0, 0, 8'd2, 0, 9'h175};
    tbl[11] = '{8'h1C, 1, 8'h1C, 0, 0, 8'd3, 1, 9'h01C};
    tbl[12] = '{8'hF0, 0, 8'h00, 0, 0, 8'd3, 1, 9'h01C};
    tbl[13] = '{8'h00, 0, 8'h00, 0, 0, 8'd3, 1, 9'h01C};
    tbl[14] = '{8'h2D, 1, 8'h2D, 0, 0, 8'd4, 1, 9'h02D};
    tbl[15] = '{8'hE0, 0, 8'h00, 0, 0, 8'd4, 1, 9'h02D};
    tbl[16] = '{8'hE0, 0, 8'h00, 0, 0, 8'd4, 1, 9'h02D};
    tbl[17] = '{8'h4A, 1, 8'h4A, 1, 0, 8'd5, 1, 9'h14A};
    tbl[18] = '{8'hF0, 0, 8'h00, 0, 0, 8'd5, 1, 9'h14A};
    tbl[19] = '{8'h2D, 1, 8'h2D, 0, 1, 8'd5, 1, 9'h14A};
    tbl[20] = '{8'hE0, 0, 8'h00, 0, 0, 8'd5, 1, 9'h14A};
    tbl[21] = '{8'hF0, 0, 8'h00, 0, 0, 8'd5, 1, 9'h14A};
    tbl[22] = '{8'hE0, 0, 8'h00, 0, 0, 8'd5, 1, 9'h14A};
    tbl[23] = '{8'h2D, 1, 8'h2D, 0, 0, 8'd6, 1, 9'h02D};
    ov = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    pool = '{8'hE0, 8'hF0, 8'h00, 8'hFF, 8'h1C, 8'h75, 8'h2D, 8'h4A, 8'h1C, 8'h1C, 8'h75, 8'h5A};

    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("reset_valid", evt_valid, 0);
    chk("reset_head", {evt_code, evt_ext, evt_break}, 0);
    chk("reset_pc", press_count, 0);
    chk("reset_held", {held, held_code}, 0);
    chk("reset_ovf", overflow, 0);

    for (int i = 0; i < 24; i++) begin
      cyc(1'b1, tbl[i].b, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_valid", i), evt_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_pc", i), press_count, tbl[i].pc);
      chk($sformatf("tbl%0d_held", i), held, tbl[i].hld);
      chk($sformatf("tbl%0d_hc", i), held_code, tbl[i].hc);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_head", i), {evt_code, evt_ext, evt_break}, {tbl[i].code, tbl[i].ext, tbl[i].brk});
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk($sformatf("tbl%0d_popped", i), evt_valid, 0);
      end
    end

    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) cyc(1'b1, ov[i], 1'b0, 1'b0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_pc", press_count, 9);
    chk("ovf_hc", held_code, 9'h044);
    chk("ovf_hold_stable", evt_code, ov[0]);
    drain();
    chk("ovf_drained", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk($sformatf("ovf_order%0d", i), got[i], {ov[i], 2'b00});
    chk("ovf_empty", evt_valid, 0);

    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b1, ov[i], 1'b0, 1'b0);
    cyc(1'b1, 8'h5A, 1'b1, 1'b0);
    chk("fullpop_ovf", overflow, 0);
    chk("fullpop_head", evt_code, ov[1]);
    drain();
    chk("fullpop_occ", got.size(), 8);
    if (got.size() == 8) chk("fullpop_last", got[7], {8'h5A, 2'b00});

    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h1C, 1'b0, 1'b0);
    chk("typ_pc", press_count, FILT ? 1 : 3);
    drain();
    chk("typ_events", got.size(), FILT ? 1 : 3);

    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'hE0, 1'b0, 1'b0);
    cyc(1'b1, 8'hF0, 1'b1, 1'b1);
    chk("rstpfx_valid", evt_valid, 0);
    cyc(1'b1, 8'h75, 1'b0, 1'b0);
    chk("rstpfx_head", {evt_valid, evt_code, evt_ext, evt_break}, {1'b1, 8'h75, 2'b00});
    chk("rstpfx_pc", press_count, 1);
    cyc(1'b1, 8'h1C, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    chk("rstfifo_head", {evt_valid, evt_code, evt_ext, evt_break}, 0);
    chk("rstfifo_state", {press_count, held, held_code, overflow}, 0);

    model_step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int c = 0; c < 4000; c++) begin
      logic bv, rdy, r;
      logic [7:0] b;
      int pct;
      pct = ((c / 250) % 2) ? 85 : 15;
      bv = $urandom_range(0, 3) != 0;
      b = pool[$urandom_range(0, 11)];
      rdy = $urandom_range(0, 99) < pct;
      r = $urandom_range(0, 299) == 0;
      model_step(bv, b, rdy, r);
      cyc(bv, b, rdy, r);
      chk("rnd_valid", evt_valid, mq.size() > 0);
      if (mq.size() > 0) chk("rnd_head", {evt_code, evt_ext, evt_break}, mq[0]);
      chk("rnd_pc", press_count, mpc);
      chk("rnd_held", {held, held_code}, {mheld, mhc});
      chk("rnd_ovf", overflow, movf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
